// File: rtl/hex_display_ctrl.sv
// Multi-digit 7-segment display controller: hex or sequential binary-to-BCD decimal, overflow dash, blink.
// Define HEX_LZ_BLANK_EN to blank leading zero digits (digit 0 always shown).
//
// state  | meaning
// S_IDLE | display stable, no conversion running
// S_CONV | shift-and-add-3 conversion, one input bit per cycle
module hex_display_ctrl #(
    parameter int DIGITS    = 6,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic                  wr_mode,
    input  logic                  blink_en,
    output logic                  busy,
    output logic [7*DIGITS-1:0]   hex_out
);

    localparam int NB = 4 * DIGITS;
    localparam int CW = $clog2(NB);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [NB-1:0] DEC_MAX    = NB'(10 ** DIGITS - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(NB - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [6:0]    SEG_BLANK  = 7'h7F;
    localparam logic [6:0]    SEG_DASH   = 7'h3F;

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   conv_cnt;
    logic [NB-1:0]   bin_sr;
    logic [NB-1:0]   bcd_sr;
    logic [NB-1:0]   bcd_adj;
    logic [NB-1:0]   bin_step;
    logic [NB-1:0]   bcd_step;
    logic [NB-1:0]   disp_val;
    logic            disp_dash;
    logic            disp_on;
    logic [BW-1:0]   blink_cnt;
    logic            blink_ph;
    logic [DIGITS-1:0] lz_blank;
    logic            dec_ok;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    assign dec_ok = (wr_data <= DEC_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A write always restarts the FSM, so the last write wins.
    always_comb begin
        state_nxt = state;
        if (wr_en) begin
            state_nxt = (wr_mode && dec_ok) ? S_CONV : S_IDLE;
        end else if (state == S_CONV && conv_cnt == '0) begin
            state_nxt = S_IDLE;
        end
    end

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
            end
        end
        {bcd_step, bin_step} = {bcd_adj, bin_sr} << 1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conv_cnt  <= '0;
            bin_sr    <= '0;
            bcd_sr    <= '0;
            disp_val  <= '0;
            disp_dash <= 1'b0;
            disp_on   <= 1'b0;
        end else if (wr_en) begin
            if (!wr_mode) begin
                disp_val  <= wr_data;
                disp_dash <= 1'b0;
                disp_on   <= 1'b1;
            end else if (!dec_ok) begin
                disp_dash <= 1'b1;
                disp_on   <= 1'b1;
            end else begin
                bin_sr   <= wr_data;
                bcd_sr   <= '0;
                conv_cnt <= CNT_LAST;
            end
        end else if (state == S_CONV) begin
            bin_sr   <= bin_step;
            bcd_sr   <= bcd_step;
            conv_cnt <= conv_cnt - 1'b1;
            // Old display is held until the final bit lands.
            if (conv_cnt == '0) begin
                disp_val  <= bcd_step;
                disp_dash <= 1'b0;
                disp_on   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

`ifdef HEX_LZ_BLANK_EN
    logic lz_seen;

    always_comb begin
        lz_seen  = 1'b0;
        lz_blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz_seen     = lz_seen || (disp_val[4*i +: 4] != 4'd0) || (i == 0);
            lz_blank[i] = !lz_seen;
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        busy    = (state == S_CONV) && !reset;
        hex_out = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (reset || !disp_on || (blink_en && blink_ph)) begin
                hex_out[7*i +: 7] = SEG_BLANK;
            end else if (disp_dash) begin
                hex_out[7*i +: 7] = SEG_DASH;
            end else if (lz_blank[i]) begin
                hex_out[7*i +: 7] = SEG_BLANK;
            end else begin
                hex_out[7*i +: 7] = seg7(disp_val[4*i +: 4]);
            end
        end
    end

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 The block SHALL have parameter DIGITS, default 6, legal range 1..8, setting the number of 7-segment digits driven.
REQ-002 The block SHALL have parameter BLINK_DIV, default 25000000, setting the blink half-period in clk cycles (0.5 s at 50 MHz).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: a one-cycle strobe that loads wr_data and wr_mode.
REQ-006 The block SHALL have port wr_data, input, 4*DIGITS bits: the value to display.
REQ-007 The block SHALL have port wr_mode, input, 1 bit: 0 = hex, 1 = unsigned decimal.
REQ-008 The block SHALL have port blink_en, input, 1 bit: when high, the whole display flashes.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a decimal conversion is in progress.
REQ-010 The block SHALL have port hex_out, output, 7*DIGITS bits: bit 7*i+k is segment k (a=0 .. g=6) of digit i, active-low; digit 0 is least significant.

Function
REQ-011 Segment encoding SHALL follow the standard active-low 0-F table, e.g. "0"=7'h40, "1"=7'h79, "8"=7'h00, "F"=7'h0E; dash=7'h3F; blank=7'h7F.
REQ-012 Hex mode: wr_en in cycle N SHALL update hex_out in cycle N+1, with nibble i driving digit i; busy stays 0.
REQ-013 Decimal mode, wr_data <= 10^DIGITS-1: the block SHALL run a sequential shift-and-add-3 conversion of one bit per cycle.
REQ-014 During that conversion, busy SHALL be 1 from N+1 for exactly 4*DIGITS cycles, and hex_out SHALL show the new BCD digits in the first cycle busy is 0.
REQ-015 Decimal mode, wr_data > 10^DIGITS-1: the block SHALL start no conversion, busy SHALL stay 0, and all digits SHALL show dash from N+1.
REQ-016 While busy, hex_out SHALL hold the previously displayed value.
REQ-017 A wr_en while busy SHALL abort the current conversion and restart with the new data and mode (last write wins), so busy runs a further 4*DIGITS cycles from the new write.
REQ-018 Mode SHALL be sampled only on wr_en; changing wr_mode without wr_en SHALL have no effect.
REQ-019 The blink counter SHALL run continuously from 0 to BLINK_DIV-1, wrap to 0, and toggle a phase bit on each wrap.
REQ-020 While blink_en=1 and phase=1, every digit SHALL be blank; otherwise the display content SHALL show.
REQ-021 blink_en SHALL take effect on hex_out within one cycle.
REQ-022 Blinking SHALL NOT affect stored data, conversion or busy.

Reset
REQ-023 While reset=1: hex_out SHALL be all blank, busy=0, stored value=0, stored mode=hex, blink counter=0, phase=0, and any conversion SHALL be discarded.
REQ-024 Reset SHALL take priority over wr_en in the same cycle.
REQ-025 After reset deasserts, the display SHALL stay blank until the first wr_en.

Configuration
REQ-026 When macro HEX_LZ_BLANK_EN is defined, zero digits above the most significant non-zero digit SHALL be blank in both modes, and digit 0 SHALL never be blanked (value 0 shows a single "0").
REQ-027 When HEX_LZ_BLANK_EN is undefined, all DIGITS digits SHALL always be shown, including leading zeros.
REQ-028 Dash (overflow) display SHALL be unaffected by HEX_LZ_BLANK_EN.

Verification (DIGITS=6, BLINK_DIV=4 for sim)
REQ-029 Reset, then hex write 24'h12AB3F -> next cycle hex_out digits 5..0 = 7'h79, 7'h24, 7'h08, 7'h03, 7'h30, 7'h0E; busy never high.
REQ-030 Decimal write 24'd999999 -> busy high exactly 24 cycles; the cycle after, all six digits = 7'h10 ("9"); old display held throughout.
REQ-031 Decimal write 24'd1000000 -> next cycle all digits 7'h3F; busy stays 0.
REQ-032 Decimal write 24'd42, then decimal write 24'd7 ten cycles later -> busy stays high 24 cycles after the second write; final display "7" (digit 0=7'h78); with HEX_LZ_BLANK_EN digits 5..1=7'h7F, without it digits 5..1=7'h40.
REQ-033 blink_en=1 with display "000005" -> hex_out alternates between the content and all-7'h7F every 4 cycles; reset asserted mid-blink forces all blank and phase=0.
REQ-034 Bench SHALL assert wr_en and reset in the same cycle -> reset state; the write SHALL be ignored.
